// File: rtl/layer_serializer_if.sv
// Bus bundle between a layer's neuron array, the serializer and the next layer's neurons.
// The serializer uses the slave modport; the producer/consumer side uses master.
interface layer_serializer_if #(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16
);
    logic                             layer_in_valid;
    logic [numNeurons*dataWidth-1:0]  layer_in;
    logic                             ser_out_valid;
    logic [dataWidth-1:0]             ser_out;
    logic                             ser_last;
    logic                             busy;
    logic                             drop_err;

    modport master (
        output layer_in_valid,
        output layer_in,
        input  ser_out_valid,
        input  ser_out,
        input  ser_last,
        input  busy,
        input  drop_err
    );

    modport slave (
        input  layer_in_valid,
        input  layer_in,
        output ser_out_valid,
        output ser_out,
        output ser_last,
        output busy,
        output drop_err
    );
endinterface

// File: rtl/layer_serializer.sv
// Captures a whole layer's parallel outputs and replays them as a serial word stream.
// Define LAYER_SERIALIZER_DOUBLE_BUF_EN to add a one-entry pending vector buffer.
module layer_serializer #(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    layer_serializer_if.slave  bus
);
    localparam int IW = $clog2(numNeurons);
    localparam logic [IW-1:0] IDX_LAST = IW'(numNeurons - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e                          state_q, state_d;
    logic [IW-1:0]                   idx_q, idx_d;
    logic [numNeurons*dataWidth-1:0] buf_q, buf_d;
    logic [dataWidth-1:0]            ser_out_q, ser_out_d;
    logic                            ser_out_valid_q, ser_out_valid_d;
    logic                            ser_last_q, ser_last_d;
    logic                            busy_q, busy_d;
    logic                            drop_err_q, drop_err_d;

    logic                            load_en;
    logic [numNeurons*dataWidth-1:0] load_data;
    logic [IW-1:0]                   idx_inc;

`ifdef LAYER_SERIALIZER_DOUBLE_BUF_EN
    logic [numNeurons*dataWidth-1:0] pend_q, pend_d;
    logic                            pend_valid_q, pend_valid_d;
`endif

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        buf_d           = buf_q;
        ser_out_d       = ser_out_q;
        ser_out_valid_d = ser_out_valid_q;
        ser_last_d      = ser_last_q;
        busy_d          = busy_q;
        drop_err_d      = 1'b0;
        load_en         = 1'b0;
        load_data       = bus.layer_in;
        idx_inc         = idx_q + 1'b1;
`ifdef LAYER_SERIALIZER_DOUBLE_BUF_EN
        pend_d          = pend_q;
        pend_valid_d    = pend_valid_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.layer_in_valid) begin
                    load_en = 1'b1;
                end
            end
            SHIFT: begin
                if (idx_q != IDX_LAST) begin
                    idx_d      = idx_inc;
                    ser_out_d  = buf_q[int'(idx_inc)*dataWidth +: dataWidth];
                    ser_last_d = (idx_inc == IDX_LAST);
`ifdef LAYER_SERIALIZER_DOUBLE_BUF_EN
                    if (bus.layer_in_valid) begin
                        if (!pend_valid_q) begin
                            pend_d       = bus.layer_in;
                            pend_valid_d = 1'b1;
                        end else begin
                            drop_err_d = 1'b1;
                        end
                    end
`else
                    drop_err_d = bus.layer_in_valid;
`endif
                end else begin
                    // Last word on the bus: chain the next vector with no gap if one exists.
`ifdef LAYER_SERIALIZER_DOUBLE_BUF_EN
                    if (pend_valid_q) begin
                        load_en      = 1'b1;
                        load_data    = pend_q;
                        pend_valid_d = bus.layer_in_valid;
                        if (bus.layer_in_valid) begin
                            pend_d = bus.layer_in;
                        end
                    end else if (bus.layer_in_valid) begin
                        load_en = 1'b1;
                    end
`else
                    if (bus.layer_in_valid) begin
                        load_en = 1'b1;
                    end
`endif
                    if (!load_en) begin
                        state_d         = IDLE;
                        ser_out_valid_d = 1'b0;
                        ser_last_d      = 1'b0;
                        busy_d          = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_en) begin
            state_d         = SHIFT;
            buf_d           = load_data;
            ser_out_d       = load_data[0 +: dataWidth];
            ser_out_valid_d = 1'b1;
            ser_last_d      = 1'b0;
            idx_d           = '0;
            busy_d          = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            buf_q           <= '0;
            ser_out_q       <= '0;
            ser_out_valid_q <= 1'b0;
            ser_last_q      <= 1'b0;
            busy_q          <= 1'b0;
            drop_err_q      <= 1'b0;
`ifdef LAYER_SERIALIZER_DOUBLE_BUF_EN
            pend_q          <= '0;
            pend_valid_q    <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            buf_q           <= buf_d;
            ser_out_q       <= ser_out_d;
            ser_out_valid_q <= ser_out_valid_d;
            ser_last_q      <= ser_last_d;
            busy_q          <= busy_d;
            drop_err_q      <= drop_err_d;
`ifdef LAYER_SERIALIZER_DOUBLE_BUF_EN
            pend_q          <= pend_d;
            pend_valid_q    <= pend_valid_d;
`endif
        end
    end

    assign bus.ser_out_valid = ser_out_valid_q;
    assign bus.ser_out       = ser_out_q;
    assign bus.ser_last      = ser_last_q;
    assign bus.busy          = busy_q;
    assign bus.drop_err      = drop_err_q;
endmodule

// File: tb/tb_layer_serializer.sv
// Directed self-checking bench for layer_serializer (4-neuron instance plus a default-size reset check).
// Drop/pending expectations follow LAYER_SERIALIZER_DOUBLE_BUF_EN.
module tb_layer_serializer;
    localparam int N = 4;
    localparam int W = 16;

    logic clk;
    logic rst_n;
    int   check_count;
    int   error_count;

    layer_serializer_if #(.numNeurons(N), .dataWidth(W)) bus ();
    layer_serializer_if #(.numNeurons(30), .dataWidth(16)) bus_def ();

    layer_serializer #(.numNeurons(N), .dataWidth(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    layer_serializer dut_def (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_def.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [N*W-1:0] VEC_A = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    localparam logic [N*W-1:0] VEC_B = {16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
    localparam logic [N*W-1:0] VEC_C = {16'h00C4, 16'h00C3, 16'h00C2, 16'h00C1};
    localparam logic [N*W-1:0] VEC_D = {16'h00D4, 16'h00D3, 16'h00D2, 16'h00D1};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge so outputs are sampled well away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N*W-1:0] vec);
        bus.layer_in       = vec;
        bus.layer_in_valid = 1'b1;
    endtask

    task automatic releaseStimulus();
        bus.layer_in_valid = 1'b0;
    endtask

    task automatic expectWord(input string tag, input logic [15:0] word, input logic last, input logic drop);
        checkOutput({tag, " valid"}, {31'd0, bus.ser_out_valid}, 32'd1);
        checkOutput({tag, " data"},  {16'd0, bus.ser_out}, {16'd0, word});
        checkOutput({tag, " last"},  {31'd0, bus.ser_last}, {31'd0, last});
        checkOutput({tag, " busy"},  {31'd0, bus.busy}, 32'd1);
        checkOutput({tag, " drop"},  {31'd0, bus.drop_err}, {31'd0, drop});
    endtask

    task automatic expectIdle(input string tag, input logic [15:0] held);
        checkOutput({tag, " valid"}, {31'd0, bus.ser_out_valid}, 32'd0);
        checkOutput({tag, " data"},  {16'd0, bus.ser_out}, {16'd0, held});
        checkOutput({tag, " last"},  {31'd0, bus.ser_last}, 32'd0);
        checkOutput({tag, " busy"},  {31'd0, bus.busy}, 32'd0);
        checkOutput({tag, " drop"},  {31'd0, bus.drop_err}, 32'd0);
    endtask

    initial begin
        check_count            = 0;
        error_count            = 0;
        rst_n                  = 1'b0;
        bus.layer_in_valid     = 1'b0;
        bus.layer_in           = '0;
        bus_def.layer_in_valid = 1'b0;
        bus_def.layer_in       = '0;

        // Reset state on both instances
        repeat (3) step();
        expectIdle("rst n4", 16'h0000);
        checkOutput("rst def valid", {31'd0, bus_def.ser_out_valid}, 32'd0);
        checkOutput("rst def data",  {16'd0, bus_def.ser_out}, 32'd0);
        checkOutput("rst def last",  {31'd0, bus_def.ser_last}, 32'd0);
        checkOutput("rst def busy",  {31'd0, bus_def.busy}, 32'd0);
        checkOutput("rst def drop",  {31'd0, bus_def.drop_err}, 32'd0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("idle def valid", {31'd0, bus_def.ser_out_valid}, 32'd0);
            checkOutput("idle n4 valid",  {31'd0, bus.ser_out_valid}, 32'd0);
        end

        // Single vector
        applyStimulus(VEC_A);
        step();
        releaseStimulus();
        expectWord("A w0", 16'h0001, 1'b0, 1'b0);
        step(); expectWord("A w1", 16'h0002, 1'b0, 1'b0);
        step(); expectWord("A w2", 16'h0003, 1'b0, 1'b0);
        step(); expectWord("A w3", 16'h0004, 1'b1, 1'b0);
        step(); expectIdle("A end", 16'h0004);
        step(); expectIdle("A end2", 16'h0004);

        // Back-to-back: second strobe coincides with ser_last
        applyStimulus(VEC_A);
        step();
        releaseStimulus();
        expectWord("AB w0", 16'h0001, 1'b0, 1'b0);
        step(); expectWord("AB w1", 16'h0002, 1'b0, 1'b0);
        step(); expectWord("AB w2", 16'h0003, 1'b0, 1'b0);
        step(); expectWord("AB w3", 16'h0004, 1'b1, 1'b0);
        applyStimulus(VEC_B);
        step();
        releaseStimulus();
        expectWord("AB w4", 16'hFFFF, 1'b0, 1'b0);
        step(); expectWord("AB w5", 16'h0000, 1'b0, 1'b0);
        step(); expectWord("AB w6", 16'h7FFF, 1'b0, 1'b0);
        step(); expectWord("AB w7", 16'h8000, 1'b1, 1'b0);
        step(); expectIdle("AB end", 16'h8000);

        // Strobes while shifting: dropped or held in pending
        applyStimulus(VEC_A);
        step();
        releaseStimulus();
        expectWord("drop w0", 16'h0001, 1'b0, 1'b0);
        step();
        expectWord("drop w1", 16'h0002, 1'b0, 1'b0);
        applyStimulus(VEC_C);
        step();
`ifdef LAYER_SERIALIZER_DOUBLE_BUF_EN
        applyStimulus(VEC_D);
        expectWord("pend w2", 16'h0003, 1'b0, 1'b0);
        step();
        releaseStimulus();
        expectWord("pend w3", 16'h0004, 1'b1, 1'b1);
        step(); expectWord("pend c0", 16'h00C1, 1'b0, 1'b0);
        step(); expectWord("pend c1", 16'h00C2, 1'b0, 1'b0);
        step(); expectWord("pend c2", 16'h00C3, 1'b0, 1'b0);
        step(); expectWord("pend c3", 16'h00C4, 1'b1, 1'b0);
        step(); expectIdle("pend end", 16'h00C4);
        step(); expectIdle("pend end2", 16'h00C4);
`else
        releaseStimulus();
        expectWord("drop w2", 16'h0003, 1'b0, 1'b1);
        step(); expectWord("drop w3", 16'h0004, 1'b1, 1'b0);
        step(); expectIdle("drop end", 16'h0004);
        step(); expectIdle("drop end2", 16'h0004);
        step(); expectIdle("drop end3", 16'h0004);
`endif

        // Asynchronous reset mid-vector, then a clean restart
        applyStimulus(VEC_A);
        step();
        releaseStimulus();
        expectWord("rstmid w0", 16'h0001, 1'b0, 1'b0);
        step(); expectWord("rstmid w1", 16'h0002, 1'b0, 1'b0);
        step(); expectWord("rstmid w2", 16'h0003, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 expectIdle("rstmid async", 16'h0000);
        #2 rst_n = 1'b1;
        step();
        expectIdle("rstmid after", 16'h0000);
        applyStimulus(VEC_B);
        step();
        releaseStimulus();
        expectWord("rst B w0", 16'hFFFF, 1'b0, 1'b0);
        step(); expectWord("rst B w1", 16'h0000, 1'b0, 1'b0);
        step(); expectWord("rst B w2", 16'h7FFF, 1'b0, 1'b0);
        step(); expectWord("rst B w3", 16'h8000, 1'b1, 1'b0);
        step(); expectIdle("rst B end", 16'h8000);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end
endmodule

// File: doc/layer_serializer.md
# layer_serializer

Inter-layer stage between neuron layers. Captures the parallel outputs of all neurons in one layer in a single cycle and replays them as a serial stream of `dataWidth` words with a valid strobe. This is the per-element `neuron_in` / `neuron_in_valid` stream that every neuron of the next layer consumes. Sits directly downstream of a layer's neuron array and upstream of the next layer's neurons.

## Interface
- `numNeurons`, 30, neurons in the producing layer; number of words per serialized vector; must be ≥ 2.
- `dataWidth`, 16, width of one neuron output word.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `layer_in_valid`  input  1  one-cycle strobe: `layer_in` holds a complete layer result.
- `layer_in`  input  numNeurons*dataWidth  packed outputs; neuron i at bits [i*dataWidth +: dataWidth].
- `ser_out_valid`  output  1  `ser_out` holds a valid word; drives next layer's `neuron_in_valid`.
- `ser_out`  output  dataWidth  current word; drives next layer's `neuron_in`.
- `ser_last`  output  1  high with the word of index numNeurons-1.
- `busy`  output  1  a vector is being emitted (state SHIFT).
- `drop_err`  output  1  one-cycle pulse: an incoming vector was discarded.

## Operation
- Reset: all outputs 0, state IDLE, index 0, pending buffer empty. Buffer contents are don't-care.
- State machine: IDLE and SHIFT. `idx` (width $clog2(numNeurons)) is the index of the word currently on `ser_out`.
- IDLE with `layer_in_valid`:
  - `layer_in` is latched into the capture buffer.
  - On the same edge, `ser_out` = word 0, `ser_out_valid` = 1, `idx` = 0, state → SHIFT.
- SHIFT with `idx` < numNeurons-1: each edge, `idx`++ and `ser_out` = buffer word `idx`+1. `ser_out_valid` stays 1.
- SHIFT with `idx` == numNeurons-1 (`ser_last` = 1):
  - If a new vector is available (`layer_in_valid` now, or the pending buffer is full), it loads and word 0 is emitted on the next edge. The stream continues with no gap; `layer_in` takes priority over pending only when pending is empty (see Configuration).
  - Otherwise, on the next edge: state → IDLE, `ser_out_valid` = 0, `ser_last` = 0, `ser_out` holds its last value.
- `layer_in_valid` in SHIFT while `idx` < numNeurons-1: handled per Configuration. Without buffering the vector is discarded and `drop_err` pulses on the following cycle.
- Data passes through unmodified. No arithmetic and no sign handling.
- `busy` = (state == SHIFT), registered.

## Timing
- Latency: `layer_in_valid` sampled at edge E → word 0 visible after E. Word k is visible after E+k. `ser_last` is visible after E+numNeurons-1.
- A single vector produces exactly numNeurons consecutive `ser_out_valid` cycles with no bubbles. The consumer has no backpressure.
- Back-to-back acceptance: `layer_in_valid` coincident with `ser_last` produces 2·numNeurons contiguous valid cycles.
- `drop_err` is registered and asserts the cycle after the discarded strobe, for one cycle.
- `rst_n` low mid-vector: outputs clear immediately (asynchronous), the remainder of the vector is lost, and `drop_err` stays 0. The first edge after release is in IDLE.

## Configuration
- `LAYER_SERIALIZER_DOUBLE_BUF_EN` defined: adds a one-entry pending buffer.
  - `layer_in_valid` in SHIFT with `idx` < numNeurons-1 and pending empty: the vector is stored in pending, with no `drop_err`.
  - At the `ser_last` edge, pending is promoted to the capture buffer and its word 0 is emitted next with no gap.
  - If `layer_in_valid` coincides with that promotion edge, the new vector goes into pending.
  - If pending is full and not being promoted, the new vector is dropped with a `drop_err` pulse.
- Not defined: no pending storage. Any strobe in SHIFT outside the `ser_last` cycle is dropped with a `drop_err` pulse.

## Test plan
- Default params, reset: hold `rst_n`=0 → all outputs 0. Release and idle 10 cycles → `ser_out_valid` stays 0.
- numNeurons=4, dataWidth=16, vector {0x0004,0x0003,0x0002,0x0001} (word0=0x0001) → `ser_out` = 0x0001, 0x0002, 0x0003, 0x0004 on the 4 cycles after the strobe. `ser_last` is high only with 0x0004, and `busy` falls the next cycle.
- numNeurons=4: second vector {0x8000,0x7FFF,0x0000,0xFFFF} strobed in the `ser_last` cycle of the first → 8 contiguous valid words, with the second sequence 0xFFFF, 0x0000, 0x7FFF, 0x8000 unchanged.
- numNeurons=4, macro off: second strobe at word index 1 → `drop_err` pulses once, the first vector completes intact, and no further valid words follow.
- numNeurons=4, macro on: second strobe at index 1 and third at index 2 → second vector follows the first gap-free, the third is dropped, and `drop_err` pulses once.
- Drive `rst_n` low at word index 2 → outputs 0 immediately. A new strobe after release emits its full 4 words from word 0.
